// File: rtl/wb_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// wb_burst_pkg: Wishbone cycle-type constants and reader FSM states. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package wb_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_burst_reader_if.sv
// -----------------------------------------------------------------------------
// wshb_if: Wishbone B4 registered-feedback bus with master/slave views. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface wshb_if #(
  parameter int ADR_WIDTH = 32
);
  logic                 clk;
  logic                 rst;
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [3:0]           sel;
  logic [2:0]           cti;
  logic [1:0]           bte;
  logic [ADR_WIDTH-1:0] adr;
  logic [31:0]          dat_ms;
  logic [31:0]          dat_sm;
  logic                 ack;

  modport master (
    output clk, rst, cyc, stb, we, sel, cti, bte, adr, dat_ms,
    input  ack, dat_sm
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, cti, bte, adr, dat_ms,
    output ack, dat_sm
  );
endinterface

`default_nettype wire

// File: rtl/wb_burst_reader_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO with first-word-fall-through head. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign empty     = (cnt == '0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_burst_reader.sv
// -----------------------------------------------------------------------------
// wb_burst_reader: reads a word region via incrementing Wishbone bursts. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_burst_reader
  import wb_burst_pkg::*;
#(
  parameter int ADR_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADR_WIDTH-1:0] base_adr,
  input  logic [LEN_WIDTH-1:0] nb_words,
  output logic                 busy,
  output logic                 done,
  wshb_if.master               wb_m,
  output logic [31:0]          s_data,
  output logic                 s_valid,
  input  logic                 s_ready
);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = ADR_WIDTH - 2;

  state_t               state;
  state_t               state_nxt;
  logic [WW-1:0]        word_adr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [BW-1:0]        beat;
  logic [BW-1:0]        blen_r;
  logic [BW-1:0]        blen;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 in_burst;
  logic                 ack_beat;
  logic                 last_beat;
  logic                 space_ok;
  logic                 launch;

  assign in_burst  = (state == BURST);
  assign ack_beat  = in_burst && wb_m.ack;
  assign last_beat = (beat == blen_r - BW'(1));
  assign blen      = (remaining >= LEN_WIDTH'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(remaining);
  // Whole burst must fit before it starts, so the slave never needs to be stalled.
  assign space_ok  = !fifo_full && ((CW'(FIFO_DEPTH) - fifo_count) >= CW'(blen));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE:       if (start && nb_words != '0) state_nxt = WAIT_SPACE;
      WAIT_SPACE: if (space_ok) begin
                    state_nxt = BURST;
                    launch    = 1'b1;
                  end
      BURST:      if (ack_beat && last_beat)
                    state_nxt = (remaining == LEN_WIDTH'(1)) ? IDLE : WAIT_SPACE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_adr  <= '0;
      remaining <= '0;
      beat      <= '0;
      blen_r    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        word_adr  <= WW'(base_adr >> 2);
        remaining <= nb_words;
        done      <= (nb_words == '0);
      end
      if (launch) begin
        blen_r <= blen;
        beat   <= '0;
      end
      if (ack_beat) begin
        word_adr  <= word_adr + WW'(1);
        remaining <= remaining - LEN_WIDTH'(1);
        beat      <= beat + BW'(1);
        if (last_beat && remaining == LEN_WIDTH'(1)) done <= 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign wb_m.clk    = clk;
  assign wb_m.rst    = rst;
  assign wb_m.cyc    = in_burst;
  assign wb_m.stb    = in_burst;
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.bte    = BTE_LINEAR;
  assign wb_m.dat_ms = 32'h0;
  assign wb_m.adr    = {word_adr, 2'b00};
  assign wb_m.cti    = in_burst ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
  assign s_valid     = !fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ack_beat),
    .push_data (wb_m.dat_sm),
    .pop       (s_ready),
    .head_data (s_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_reader: directed + randomized bench with BRAM slave and reference queues. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wb_burst_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] base_adr = '0;
  logic [15:0] nb_words = '0;
  logic        busy;
  logic        done;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int acks = 0;
  int pops = 0;
  int done_cnt = 0;
  int ready_mode = 1;
  bit stall_en = 1'b0;
  bit saw_cyc = 1'b0;
  bit saw_busy = 1'b0;
  bit prev_eob = 1'b0;
  bit prev_wait = 1'b0;
  logic [12:0] pw_adr;
  logic [2:0]  pw_cti;

  logic [31:0] mem [2048];
  logic [10:0] nxt;
  logic [12:0] exp_adr_q [$];
  logic [2:0]  exp_cti_q [$];
  logic [31:0] exp_data_q [$];

  wshb_if #(.ADR_WIDTH(13)) bus ();

  wb_burst_reader #(
    .ADR_WIDTH  (13),
    .LEN_WIDTH  (16),
    .BURST_LEN  (8),
    .FIFO_DEPTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_adr (base_adr),
    .nb_words (nb_words),
    .busy     (busy),
    .done     (done),
    .wb_m     (bus),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // BlockRAM slave: registered ack, so the first beat of every burst has a wait state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack    <= 1'b0;
      bus.dat_sm <= '0;
    end else if (bus.cyc && bus.stb && !(bus.ack && bus.cti == 3'b111)) begin
      nxt = bus.ack ? bus.adr[12:2] + 11'd1 : bus.adr[12:2];
      bus.ack    <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.dat_sm <= mem[nxt];
    end else begin
      bus.ack <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       s_ready = 1'b0;
      1:       s_ready = 1'b1;
      default: s_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      acks = 0;
      pops = 0;
      prev_eob = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (prev_eob) chk("cyc_drop_after_eob", {31'b0, bus.cyc}, 32'd0);
      prev_eob = 1'b0;
      if (prev_wait && bus.stb) begin
        chk("wait_adr_stable", {19'b0, bus.adr}, {19'b0, pw_adr});
        chk("wait_cti_stable", {29'b0, bus.cti}, {29'b0, pw_cti});
      end
      prev_wait = bus.cyc && bus.stb && !bus.ack;
      pw_adr = bus.adr;
      pw_cti = bus.cti;
      if (bus.cyc) saw_cyc = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (bus.cyc && bus.stb && bus.ack) begin
        if (exp_adr_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("beat_adr", {19'b0, bus.adr}, {19'b0, exp_adr_q.pop_front()});
          chk("beat_cti", {29'b0, bus.cti}, {29'b0, exp_cti_q.pop_front()});
        end
        acks++;
        chk("fifo_no_overflow", {31'b0, (acks - pops) <= 32}, 32'd1);
        prev_eob = (bus.cti == 3'b111);
      end
      if (s_valid && s_ready) begin
        if (exp_data_q.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
        else chk("stream_data", s_data, exp_data_q.pop_front());
        pops++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Reference: split the request into bursts of min(8, remaining) words.
  task automatic start_xfer(input logic [12:0] base, input int n, input int hold);
    int rem = n;
    logic [10:0] a = base[12:2];
    while (rem > 0) begin
      int b = (rem > 8) ? 8 : rem;
      for (int j = 0; j < b; j++) begin
        exp_adr_q.push_back({a, 2'b00});
        exp_cti_q.push_back((j == b - 1) ? 3'b111 : 3'b010);
        exp_data_q.push_back(mem[a]);
        a = a + 11'd1;
        rem--;
      end
    end
    saw_cyc = 1'b0;
    saw_busy = 1'b0;
    @(posedge clk); #1;
    base_adr = base;
    nb_words = 16'(n);
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, {31'b0, done_cnt != d0}, 32'd1);
    for (int i = 0; i < 3000 && exp_data_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_beats_left"}, 32'(exp_adr_q.size()), 32'd0);
    chk({tag, "_words_left"}, 32'(exp_data_q.size()), 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_xfer(input string tag, input logic [12:0] base, input int n, input int hold);
    int d0 = done_cnt;
    start_xfer(base, n, hold);
    finish_xfer(tag, d0);
  endtask

  initial begin
    int d0;
    int a0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) mem[32'h40 + i] = i;

    #3;
    chk("rst_cyc", {31'b0, bus.cyc}, 32'd0);
    chk("rst_stb", {31'b0, bus.stb}, 32'd0);
    chk("rst_we", {31'b0, bus.we}, 32'd0);
    chk("rst_sel", {28'b0, bus.sel}, 32'hF);
    chk("rst_cti", {29'b0, bus.cti}, 32'd0);
    chk("rst_bte", {30'b0, bus.bte}, 32'd0);
    chk("rst_adr", {19'b0, bus.adr}, 32'd0);
    chk("rst_dat_ms", bus.dat_ms, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    ready_mode = 1; stall_en = 1'b0;
    run_xfer("single", 13'h100, 8, 1);

    ready_mode = 2; stall_en = 1'b1;
    run_xfer("multi", 13'h200, 20, 1);

    ready_mode = 0; stall_en = 1'b0;
    d0 = done_cnt;
    a0 = acks;
    start_xfer(13'h400, 64, 1);
    for (int i = 0; i < 500 && (acks - a0) < 32; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("bp_acks_at_full", 32'(acks - a0), 32'd32);
    chk("bp_cyc_low", {31'b0, bus.cyc}, 32'd0);
    chk("bp_busy", {31'b0, busy}, 32'd1);
    chk("bp_s_valid", {31'b0, s_valid}, 32'd1);
    ready_mode = 1;
    finish_xfer("backpressure", d0);

    run_xfer("len0", 13'h080, 0, 1);
    chk("len0_no_cyc", {31'b0, saw_cyc}, 32'd0);
    chk("len0_no_busy", {31'b0, saw_busy}, 32'd0);

    run_xfer("len1", 13'h0A4, 1, 1);

    ready_mode = 2;
    run_xfer("start_held", 13'h600, 5, 3);

    stall_en = 1'b1;
    run_xfer("wrap", 13'h1FF8, 4, 1);

    ready_mode = 1; stall_en = 1'b0;
    a0 = acks;
    start_xfer(13'h300, 16, 1);
    for (int i = 0; i < 200 && (acks - a0) < 3; i++) @(negedge clk);
    chk("midrst_beat3_reached", {31'b0, (acks - a0) >= 3}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_cyc", {31'b0, bus.cyc}, 32'd0);
    chk("midrst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    exp_adr_q.delete();
    exp_cti_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_xfer("after_rst", 13'h340, 2, 1);

    for (int k = 0; k < 4; k++) begin
      ready_mode = 2;
      stall_en = 1'($urandom_range(0, 1));
      run_xfer("random", 13'($urandom), $urandom_range(1, 40), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
